// File: rtl/tea_cbc_ctrl.sv
// CBC-mode controller in front of the TEA core.
// Chains plaintext with IV/ciphertext and streams results.
module tea_cbc_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      iv,
  input  logic [127:0]     key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_blk,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_blk,
  output logic             out_last,
  output logic             core_ptxt_valid,
  output logic             core_key_valid,
  output logic [63:0]      core_ptxt_blk,
  output logic [127:0]     core_key,
  input  logic [63:0]      core_ctxt_blk,
  input  logic             core_ctxt_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             timeout
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_ISSUE,
    S_WAIT_CT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      chain_q, chain_d;
  logic [127:0]     key_q, key_d;
  logic [63:0]      data_q, data_d;
  logic             last_q, last_d;
  logic [63:0]      oblk_q, oblk_d;
  logic             olast_q, olast_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             req_q, req_d;

  // Next-state and datapath updates for the chaining FSM.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    key_d   = key_q;
    data_d  = data_q;
    last_d  = last_q;
    oblk_d  = oblk_q;
    olast_d = olast_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    req_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          chain_d = iv;
          key_d   = key;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          data_d  = in_blk ^ chain_q;
          last_d  = in_last;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!core_ctxt_ready) begin
          req_d   = 1'b1;
          wcnt_d  = '0;
          state_d = S_WAIT_CT;
        end
      end
      S_WAIT_CT: begin
        if (core_ctxt_ready) begin
          chain_d = core_ctxt_blk;
          oblk_d  = core_ctxt_blk;
          olast_d = last_q;
          state_d = S_OUT;
        end else if (wcnt_q == WMAX) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = olast_q ? S_IDLE : S_WAIT_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chain_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      oblk_q  <= '0;
      olast_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      key_q   <= key_d;
      data_q  <= data_d;
      last_q  <= last_d;
      oblk_q  <= oblk_d;
      olast_q <= olast_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
    end
  end

  assign in_ready        = (state_q == S_WAIT_IN);
  assign out_valid       = (state_q == S_OUT);
  assign busy            = (state_q != S_IDLE);
  assign out_blk         = oblk_q;
  assign out_last        = olast_q;
  assign core_ptxt_valid = req_q;
  assign core_key_valid  = req_q;
  assign core_ptxt_blk   = data_q;
  assign core_key        = key_q;
  assign blk_cnt         = cnt_q;
  assign timeout         = tmo_q;

endmodule
